bp_clint_responder: RTL and testbench

- Memory-mapped responder for the CLINT device window (device ID 3, base 0x0030_0000). It also holds the PLIC external-interrupt stub.
- Accepts single-beat uncached load/store commands from the I/O network and returns one response per command.
- Owns mipi, mtimecmp, mtime and plic registers.
- Drives software/timer/external interrupt lines to one core.

---
 rtl/bp_clint_responder.sv | 188 ++++++++++++++++++
 tb/tb_bp_clint_responder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_clint_responder.sv
// CLINT device-window responder: mipi / mtimecmp / mtime / PLIC-stub registers behind a
// single-beat load/store port, with one response per command and the three core IRQ lines.
module bp_clint_responder #(
   parameter int unsigned                 paddr_width_p   = 40,
   parameter int unsigned                 data_width_p    = 64,
   parameter logic [paddr_width_p-1:0]    mipi_addr_p     = 40'h00_0030_0000,
   parameter logic [paddr_width_p-1:0]    mtimecmp_addr_p = 40'h00_0030_4000,
   parameter logic [paddr_width_p-1:0]    mtime_addr_p    = 40'h00_0030_bff8,
   parameter logic [paddr_width_p-1:0]    plic_addr_p     = 40'h00_0030_b000
) (
   input  logic                     clk_i,
   input  logic                     reset_i,

   input  logic                     mem_cmd_v_i,
   output logic                     mem_cmd_ready_o,
   input  logic                     mem_cmd_w_i,
   input  logic [paddr_width_p-1:0] mem_cmd_addr_i,
   input  logic [1:0]               mem_cmd_size_i,
   input  logic [data_width_p-1:0]  mem_cmd_data_i,

   output logic                     mem_resp_v_o,
   input  logic                     mem_resp_yumi_i,
   output logic                     mem_resp_w_o,
   output logic [paddr_width_p-1:0] mem_resp_addr_o,
   output logic [1:0]               mem_resp_size_o,
   output logic [data_width_p-1:0]  mem_resp_data_o,
   output logic                     mem_resp_err_o,

   input  logic                     rtc_tick_i,
   output logic                     software_irq_o,
   output logic                     timer_irq_o,
   output logic                     external_irq_o
);

   typedef enum logic {StReady, StResp} state_e;

   state_e                   state_q, state_d;
   logic                     mipi_q, mipi_d;
   logic                     plic_q, plic_d;
   logic [63:0]              mtime_q, mtime_d;
   logic [63:0]              mtimecmp_q, mtimecmp_d;
   logic                     resp_w_q, resp_w_d;
   logic [paddr_width_p-1:0] resp_addr_q, resp_addr_d;
   logic [1:0]               resp_size_q, resp_size_d;
   logic [63:0]              resp_data_q, resp_data_d;
   logic                     resp_err_q, resp_err_d;

   logic [paddr_width_p-1:0] reg_addr;
   logic [2:0]               offset;
   logic [5:0]               bit_shift;
   logic                     hit_mipi, hit_mtimecmp, hit_mtime, hit_plic, hit_any;
   logic                     misaligned, access_err;
   logic                     accept, do_write;
   logic [7:0]               size_bytes, byte_mask;
   logic [63:0]              bit_mask, wdata, size_mask, rd_reg, ld_data;

   // Address decode, alignment and byte-lane generation
   always_comb begin
      reg_addr     = {mem_cmd_addr_i[paddr_width_p-1:3], 3'b000};
      offset       = mem_cmd_addr_i[2:0];
      bit_shift    = {offset, 3'b000};
      hit_mipi     = (reg_addr == mipi_addr_p);
      hit_mtimecmp = (reg_addr == mtimecmp_addr_p);
      hit_mtime    = (reg_addr == mtime_addr_p);
      hit_plic     = (reg_addr == plic_addr_p);
      hit_any      = hit_mipi | hit_mtimecmp | hit_mtime | hit_plic;

      misaligned = 1'b0;
      size_bytes = 8'h01;
      size_mask  = 64'h0000_0000_0000_00ff;
      unique case (mem_cmd_size_i)
         2'd0: begin
            misaligned = 1'b0;
            size_bytes = 8'h01;
            size_mask  = 64'h0000_0000_0000_00ff;
         end
         2'd1: begin
            misaligned = offset[0];
            size_bytes = 8'h03;
            size_mask  = 64'h0000_0000_0000_ffff;
         end
         2'd2: begin
            misaligned = |offset[1:0];
            size_bytes = 8'h0f;
            size_mask  = 64'h0000_0000_ffff_ffff;
         end
         2'd3: begin
            misaligned = |offset;
            size_bytes = 8'hff;
            size_mask  = 64'hffff_ffff_ffff_ffff;
         end
         default: ;
      endcase

      access_err = ~hit_any | misaligned;
      byte_mask  = size_bytes << offset;
      for (int i = 0; i < 8; i++) begin
         bit_mask[8*i +: 8] = {8{byte_mask[i]}};
      end
      wdata = mem_cmd_data_i << bit_shift;

      rd_reg = 64'd0;
      if (hit_mipi)     rd_reg = {63'd0, mipi_q};
      if (hit_mtimecmp) rd_reg = mtimecmp_q;
      if (hit_mtime)    rd_reg = mtime_q;
      if (hit_plic)     rd_reg = {63'd0, plic_q};
      ld_data = (rd_reg >> bit_shift) & size_mask;
   end

   // Next-state: FSM, register writes, mtime tick and response capture
   always_comb begin
      state_d     = state_q;
      mipi_d      = mipi_q;
      plic_d      = plic_q;
      mtimecmp_d  = mtimecmp_q;
      mtime_d     = rtc_tick_i ? mtime_q + 64'd1 : mtime_q;
      resp_w_d    = resp_w_q;
      resp_addr_d = resp_addr_q;
      resp_size_d = resp_size_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;

      accept   = (state_q == StReady) && mem_cmd_v_i;
      do_write = accept && mem_cmd_w_i && !access_err;

      unique case (state_q)
         StReady: if (mem_cmd_v_i) state_d = StResp;
         StResp:  if (mem_resp_yumi_i) state_d = StReady;
         default: state_d = StReady;
      endcase

      if (accept) begin
         resp_w_d    = mem_cmd_w_i;
         resp_addr_d = mem_cmd_addr_i;
         resp_size_d = mem_cmd_size_i;
         resp_data_d = (mem_cmd_w_i || access_err) ? 64'd0 : ld_data;
         resp_err_d  = access_err;
      end

      if (do_write) begin
         if (hit_mipi && byte_mask[0]) mipi_d = wdata[0];
         if (hit_plic && byte_mask[0]) plic_d = wdata[0];
         if (hit_mtimecmp) mtimecmp_d = (mtimecmp_q & ~bit_mask) | (wdata & bit_mask);
         // A store to mtime replaces the whole tick update for this cycle
         if (hit_mtime)    mtime_d    = (mtime_q & ~bit_mask) | (wdata & bit_mask);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= StReady;
         mipi_q      <= 1'b0;
         plic_q      <= 1'b0;
         mtime_q     <= 64'd0;
         mtimecmp_q  <= 64'hffff_ffff_ffff_ffff;
         resp_w_q    <= 1'b0;
         resp_addr_q <= '0;
         resp_size_q <= 2'd0;
         resp_data_q <= 64'd0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         mipi_q      <= mipi_d;
         plic_q      <= plic_d;
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         resp_w_q    <= resp_w_d;
         resp_addr_q <= resp_addr_d;
         resp_size_q <= resp_size_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

   always_comb begin
      mem_cmd_ready_o = (state_q == StReady);
      mem_resp_v_o    = (state_q == StResp);
      mem_resp_w_o    = resp_w_q;
      mem_resp_addr_o = resp_addr_q;
      mem_resp_size_o = resp_size_q;
      mem_resp_data_o = resp_data_q;
      mem_resp_err_o  = resp_err_q;
      software_irq_o  = mipi_q;
      external_irq_o  = plic_q;
      timer_irq_o     = (mtime_q >= mtimecmp_q);
   end

endmodule

// File: tb/tb_bp_clint_responder.sv
// Directed plus randomized bench for bp_clint_responder; a byte-level register model inside the
// bench predicts every response and interrupt level.
module tb_bp_clint_responder;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        mem_cmd_v_i, mem_cmd_ready_o, mem_cmd_w_i;
   logic [39:0] mem_cmd_addr_i;
   logic [1:0]  mem_cmd_size_i;
   logic [63:0] mem_cmd_data_i;
   logic        mem_resp_v_o, mem_resp_yumi_i, mem_resp_w_o;
   logic [39:0] mem_resp_addr_o;
   logic [1:0]  mem_resp_size_o;
   logic [63:0] mem_resp_data_o;
   logic        mem_resp_err_o;
   logic        rtc_tick_i;
   logic        software_irq_o, timer_irq_o, external_irq_o;

   bp_clint_responder dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .mem_cmd_v_i     (mem_cmd_v_i),
      .mem_cmd_ready_o (mem_cmd_ready_o),
      .mem_cmd_w_i     (mem_cmd_w_i),
      .mem_cmd_addr_i  (mem_cmd_addr_i),
      .mem_cmd_size_i  (mem_cmd_size_i),
      .mem_cmd_data_i  (mem_cmd_data_i),
      .mem_resp_v_o    (mem_resp_v_o),
      .mem_resp_yumi_i (mem_resp_yumi_i),
      .mem_resp_w_o    (mem_resp_w_o),
      .mem_resp_addr_o (mem_resp_addr_o),
      .mem_resp_size_o (mem_resp_size_o),
      .mem_resp_data_o (mem_resp_data_o),
      .mem_resp_err_o  (mem_resp_err_o),
      .rtc_tick_i      (rtc_tick_i),
      .software_irq_o  (software_irq_o),
      .timer_irq_o     (timer_irq_o),
      .external_irq_o  (external_irq_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   bit rand_tick = 1'b0;

   // Model: 0=mipi, 1=mtimecmp, 2=mtime, 3=plic
   logic [63:0] m_reg [4];
   bit          m_busy;
   logic        m_w, m_err;
   logic [39:0] m_addr;
   logic [1:0]  m_size;
   logic [63:0] m_data;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      bit   tick_ok;
      int   idx, n, off;
      logic [39:0] base;
      tick_ok = rtc_tick_i;
      if (reset_i) begin
         m_reg[0] = 64'd0;
         m_reg[1] = '1;
         m_reg[2] = 64'd0;
         m_reg[3] = 64'd0;
         m_busy = 0; m_w = 0; m_err = 0; m_addr = '0; m_size = '0; m_data = '0;
         return;
      end
      if (!m_busy && mem_cmd_v_i) begin
         m_busy = 1;
         m_w = mem_cmd_w_i; m_addr = mem_cmd_addr_i; m_size = mem_cmd_size_i; m_data = 64'd0;
         base = {mem_cmd_addr_i[39:3], 3'b000};
         off  = int'(mem_cmd_addr_i[2:0]);
         n    = 1 << mem_cmd_size_i;
         case (base)
            40'h00_0030_0000: idx = 0;
            40'h00_0030_4000: idx = 1;
            40'h00_0030_bff8: idx = 2;
            40'h00_0030_b000: idx = 3;
            default:          idx = -1;
         endcase
         m_err = (idx < 0) || ((off % n) != 0);
         if (!m_err) begin
            for (int i = 0; i < n; i++) begin
               if (mem_cmd_w_i) m_reg[idx][8*(off+i) +: 8] = mem_cmd_data_i[8*i +: 8];
               else             m_data[8*i +: 8] = m_reg[idx][8*(off+i) +: 8];
            end
            if (idx == 0 || idx == 3) m_reg[idx] = m_reg[idx] & 64'd1;
            if (mem_cmd_w_i && idx == 2) tick_ok = 0;
         end
      end else if (m_busy && mem_resp_yumi_i) begin
         m_busy = 0;
      end
      if (tick_ok) m_reg[2] = m_reg[2] + 64'd1;
   endtask

   task automatic cycle();
      @(posedge clk_i);
      model_step();
      @(negedge clk_i);
      if (rand_tick) rtc_tick_i = 1'($urandom_range(0, 1));
   endtask

   task automatic check_irqs(input string tag);
      check({tag, ".sw_irq"},    {63'd0, software_irq_o}, {63'd0, m_reg[0][0]});
      check({tag, ".ext_irq"},   {63'd0, external_irq_o}, {63'd0, m_reg[3][0]});
      check({tag, ".timer_irq"}, {63'd0, timer_irq_o},    {63'd0, m_reg[2] >= m_reg[1]});
   endtask

   // One full command/response handshake, entered and left at a negedge
   task automatic cmd(input logic w, input logic [39:0] a, input logic [1:0] sz,
                      input logic [63:0] d, input int hold, input bit tick_pulse,
                      output logic [63:0] rdata, output logic rerr);
      check("cmd_ready_idle", {63'd0, mem_cmd_ready_o}, 64'd1);
      mem_cmd_v_i = 1; mem_cmd_w_i = w; mem_cmd_addr_i = a; mem_cmd_size_i = sz;
      mem_cmd_data_i = d;
      if (tick_pulse) rtc_tick_i = 1;
      cycle();
      mem_cmd_v_i = 0;
      if (tick_pulse) rtc_tick_i = 0;
      check("resp_v",    {63'd0, mem_resp_v_o},    64'd1);
      check("cmd_ready", {63'd0, mem_cmd_ready_o}, 64'd0);
      check("resp_w",    {63'd0, mem_resp_w_o},    {63'd0, m_w});
      check("resp_addr", {24'd0, mem_resp_addr_o}, {24'd0, m_addr});
      check("resp_size", {62'd0, mem_resp_size_o}, {62'd0, m_size});
      check("resp_data", mem_resp_data_o,          m_data);
      check("resp_err",  {63'd0, mem_resp_err_o},  {63'd0, m_err});
      rdata = mem_resp_data_o;
      rerr  = mem_resp_err_o;
      for (int i = 0; i < hold; i++) begin
         cycle();
         check("hold_v",    {63'd0, mem_resp_v_o}, 64'd1);
         check("hold_data", mem_resp_data_o,       m_data);
      end
      mem_resp_yumi_i = 1;
      cycle();
      mem_resp_yumi_i = 0;
      check("resp_v_after_yumi", {63'd0, mem_resp_v_o}, 64'd0);
      check_irqs("post_cmd");
   endtask

   logic [63:0] rd;
   logic        re;
   logic [39:0] rbase [5];

   initial begin
      reset_i = 1; mem_cmd_v_i = 0; mem_cmd_w_i = 0; mem_cmd_addr_i = '0; mem_cmd_size_i = '0;
      mem_cmd_data_i = '0; mem_resp_yumi_i = 0; rtc_tick_i = 0;
      cycle(); cycle();
      check("rst.resp_v",    {63'd0, mem_resp_v_o},    64'd0);
      check("rst.cmd_ready", {63'd0, mem_cmd_ready_o}, 64'd1);
      check("rst.resp_data", mem_resp_data_o,          64'd0);
      check("rst.resp_err",  {63'd0, mem_resp_err_o},  64'd0);
      check("rst.resp_addr", {24'd0, mem_resp_addr_o}, 64'd0);
      check_irqs("rst");
      reset_i = 0;

      // mtimecmp reset value, response held while yumi low
      cmd(0, 40'h00_0030_4000, 2'd3, 64'd0, 3, 0, rd, re);
      check("mtimecmp_rst", rd, 64'hffff_ffff_ffff_ffff);

      // Timer interrupt rises when mtime reaches mtimecmp
      cmd(1, 40'h00_0030_4000, 2'd3, 64'd5, 0, 0, rd, re);
      for (int i = 0; i < 6; i++) begin
         rtc_tick_i = 1;
         cycle();
         check("timer_ramp", {63'd0, timer_irq_o}, {63'd0, i >= 4});
      end
      rtc_tick_i = 0;
      cmd(0, 40'h00_0030_bff8, 2'd3, 64'd0, 0, 0, rd, re);
      check("mtime_six", rd, 64'd6);

      // Upper-word store into mtime
      cmd(1, 40'h00_0030_bff8, 2'd3, 64'd0, 0, 0, rd, re);
      cmd(1, 40'h00_0030_bffc, 2'd2, 64'd1, 0, 0, rd, re);
      cmd(0, 40'h00_0030_bff8, 2'd3, 64'd0, 0, 0, rd, re);
      check("mtime_hi", rd, 64'h0000_0001_0000_0000);
      cmd(0, 40'h00_0030_bff8, 2'd2, 64'd0, 0, 0, rd, re);
      check("mtime_lo32", rd, 64'd0);
      cmd(0, 40'h00_0030_bffc, 2'd2, 64'd0, 1, 0, rd, re);
      check("mtime_hi32", rd, 64'd1);

      // Software and external interrupt bits
      cmd(1, 40'h00_0030_0000, 2'd0, 64'hff, 0, 0, rd, re);
      check("sw_irq_set", {63'd0, software_irq_o}, 64'd1);
      cmd(0, 40'h00_0030_0000, 2'd3, 64'd0, 0, 0, rd, re);
      check("mipi_read", rd, 64'd1);
      cmd(1, 40'h00_0030_0000, 2'd0, 64'h0, 0, 0, rd, re);
      check("sw_irq_clr", {63'd0, software_irq_o}, 64'd0);
      cmd(1, 40'h00_0030_b000, 2'd0, 64'hff, 0, 0, rd, re);
      check("ext_irq_set", {63'd0, external_irq_o}, 64'd1);
      cmd(0, 40'h00_0030_b000, 2'd3, 64'd0, 0, 0, rd, re);
      check("plic_read", rd, 64'd1);
      cmd(1, 40'h00_0030_b000, 2'd0, 64'h0, 0, 0, rd, re);
      check("ext_irq_clr", {63'd0, external_irq_o}, 64'd0);

      // Unmapped and misaligned accesses
      cmd(0, 40'h00_0030_2000, 2'd3, 64'd0, 0, 0, rd, re);
      check("unmapped_err", {63'd0, re}, 64'd1);
      check("unmapped_data", rd, 64'd0);
      cmd(1, 40'h00_0030_4002, 2'd2, 64'h1234_5678, 0, 0, rd, re);
      check("misaligned_err", {63'd0, re}, 64'd1);
      cmd(0, 40'h00_0030_4000, 2'd3, 64'd0, 0, 0, rd, re);
      check("mtimecmp_kept", rd, 64'd5);

      // mtime wrap, and store winning over a coincident tick
      cmd(1, 40'h00_0030_bff8, 2'd3, 64'hffff_ffff_ffff_ffff, 0, 0, rd, re);
      rtc_tick_i = 1;
      cycle();
      rtc_tick_i = 0;
      cmd(0, 40'h00_0030_bff8, 2'd3, 64'd0, 0, 0, rd, re);
      check("mtime_wrap", rd, 64'd0);
      cmd(1, 40'h00_0030_bff8, 2'd3, 64'd7, 0, 1, rd, re);
      cmd(0, 40'h00_0030_bff8, 2'd3, 64'd0, 0, 0, rd, re);
      check("mtime_store_wins", rd, 64'd7);

      // Reset while a response is pending
      cmd(1, 40'h00_0030_0000, 2'd3, 64'd1, 0, 0, rd, re);
      cmd(1, 40'h00_0030_b000, 2'd3, 64'd1, 0, 0, rd, re);
      mem_cmd_v_i = 1; mem_cmd_w_i = 1; mem_cmd_addr_i = 40'h00_0030_4000;
      mem_cmd_size_i = 2'd3; mem_cmd_data_i = 64'd3;
      cycle();
      mem_cmd_v_i = 0;
      check("pre_rst.resp_v", {63'd0, mem_resp_v_o}, 64'd1);
      reset_i = 1;
      cycle();
      reset_i = 0;
      check("mid_rst.resp_v",    {63'd0, mem_resp_v_o},    64'd0);
      check("mid_rst.cmd_ready", {63'd0, mem_cmd_ready_o}, 64'd1);
      check_irqs("mid_rst");
      cmd(0, 40'h00_0030_4000, 2'd3, 64'd0, 0, 0, rd, re);
      check("mid_rst.mtimecmp", rd, 64'hffff_ffff_ffff_ffff);
      cmd(0, 40'h00_0030_0000, 2'd3, 64'd0, 0, 0, rd, re);
      check("mid_rst.mipi", rd, 64'd0);

      // Randomized traffic against the model
      rbase[0] = 40'h00_0030_0000; rbase[1] = 40'h00_0030_4000; rbase[2] = 40'h00_0030_bff8;
      rbase[3] = 40'h00_0030_b000; rbase[4] = 40'h00_0030_2000;
      rand_tick = 1;
      for (int k = 0; k < 80; k++) begin
         logic [39:0] a;
         logic [63:0] d;
         a = rbase[$urandom_range(0, 4)] | 40'($urandom_range(0, 7));
         d = {$urandom, $urandom};
         cmd(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), d,
             $urandom_range(0, 2), 0, rd, re);
      end
      rand_tick = 0;
      rtc_tick_i = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
